// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction fetch sequencer
package fetch_pkg;
  typedef enum logic [1:0] {IDLE, FETCH, HALTED} state_t;
  localparam logic [31:0] HALT_DEFAULT = 32'hFFFF_FFFF;
  typedef struct packed {
    logic [31:0] instr;
    logic [7:0]  pc;
  } entry_t;
endpackage

// File: rtl/fetch_sequencer_instr_queue2.sv
// instr_queue2: two-entry FIFO with flush; head entry is held in a register
module instr_queue2 #(
  parameter type T = fetch_pkg::entry_t
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  logic       pop,
  input  logic       flush,
  input  T           din,
  output T           head,
  output logic [1:0] count
);
  T tail;
  // entries shift toward the head on pop; new data lands in the first free slot
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      count <= '0;
    end else begin
      count <= count + 2'(push) - 2'(pop);
      if (pop && count == 2'd2) head <= tail;
      else if (push && (count == 2'd0 || (count == 2'd1 && pop))) head <= din;
      if (push && (count == 2'd2 || (count == 2'd1 && !pop))) tail <= din;
    end
endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: owns the pc, issues ROM reads and buffers returned instructions for decode
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int                 ADDR_W     = 8,
  parameter int                 DATA_W     = 32,
  parameter logic [ADDR_W-1:0]  RESET_PC   = '0,
  parameter logic [DATA_W-1:0]  HALT_INSTR = DATA_W'(HALT_DEFAULT)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic [ADDR_W-1:0] imem_addr,
  output logic              imem_rd_en,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic [DATA_W-1:0] instr_out,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              instr_valid,
  input  logic              instr_ready,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              halted
);
  typedef struct packed {
    logic [DATA_W-1:0] instr;
    logic [ADDR_W-1:0] pc;
  } q_entry_t;
  state_t            state, state_nx;
  logic [ADDR_W-1:0] pc, iss_addr;
  logic              inflight, redir, pop, push, resp_halt, fetching, issue;
  logic [1:0]        count;
  logic [2:0]        occ;
  q_entry_t          head;
  assign redir       = redirect_valid && state != IDLE;
  assign instr_valid = count != 2'd0;
  assign pop         = instr_valid && instr_ready;
  assign push        = inflight && !redir;
  assign resp_halt   = push && imem_rdata == HALT_INSTR;
  assign fetching    = state == FETCH || (state == IDLE && start && !redirect_valid);
  // occupancy after this edge; issuing is safe while it leaves room for the returning word
  assign occ         = {1'b0, count} + {2'b0, inflight} - {2'b0, pop};
  assign issue       = reset && fetching && !redir && !resp_halt && occ < 3'd2;
  assign imem_rd_en  = issue;
  assign imem_addr   = pc;
  assign halted      = state == HALTED;
  assign instr_out   = head.instr;
  assign instr_pc    = head.pc;
  // next state: redirect dominates, then start from idle, then halt on a returned HALT word
  always_comb
    state_nx = redir ? FETCH :
               (state == IDLE && start) ? FETCH :
               resp_halt ? HALTED : state;
  // state, pc and the single outstanding-read tracker
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state    <= IDLE;
      pc       <= RESET_PC;
      inflight <= 1'b0;
      iss_addr <= RESET_PC;
    end else begin
      state    <= state_nx;
      inflight <= issue;
      pc       <= redirect_valid ? redirect_pc : issue ? pc + ADDR_W'(1) : pc;
      if (issue) iss_addr <= pc;
    end
  instr_queue2 #(.T(q_entry_t)) u_q (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .flush (redir),
    .din   ('{instr: imem_rdata, pc: iss_addr}),
    .head  (head),
    .count (count)
  );
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: randomized scoreboard bench for the fetch sequencer
module tb_fetch_sequencer;
  localparam logic [31:0] HALT = 32'hFFFF_FFFF;
  typedef struct {
    logic [31:0] instr;
    logic [7:0]  pc;
  } exp_t;
  logic        clk = 0, reset = 1, start = 0, ready = 0, redirect_valid = 0;
  logic [7:0]  redirect_pc = 0;
  logic [7:0]  imem_addr, instr_pc;
  logic        imem_rd_en, instr_valid, halted;
  logic [31:0] imem_rdata, instr_out;
  logic [31:0] rom [256];
  logic        start2 = 0;
  logic [3:0]  imem_addr2, instr_pc2;
  logic        imem_rd_en2, instr_valid2, halted2;
  logic [31:0] imem_rdata2, instr_out2;
  logic [31:0] rom2 [16];
  logic [3:0]  iss2 [$];
  exp_t        expq [$];
  exp_t        me;
  bit          running = 0;
  logic [7:0]  mpc = 0;
  int          vectors = 0, miscompares = 0;

  fetch_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .imem_addr(imem_addr), .imem_rd_en(imem_rd_en),
    .imem_rdata(imem_rdata), .instr_out(instr_out), .instr_pc(instr_pc), .instr_valid(instr_valid),
    .instr_ready(ready), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .halted(halted)
  );
  fetch_sequencer #(.ADDR_W(4), .RESET_PC(4'd14)) d2 (
    .clk(clk), .reset(reset), .start(start2), .imem_addr(imem_addr2), .imem_rd_en(imem_rd_en2),
    .imem_rdata(imem_rdata2), .instr_out(instr_out2), .instr_pc(instr_pc2), .instr_valid(instr_valid2),
    .instr_ready(1'b1), .redirect_valid(1'b0), .redirect_pc(4'd0), .halted(halted2)
  );

  always #5 clk = ~clk;
  always @(posedge clk) if (imem_rd_en) imem_rdata <= rom[imem_addr];
  always @(posedge clk) if (imem_rd_en2) imem_rdata2 <= rom2[imem_addr2];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // expected delivery after a start/redirect: consecutive words up to and including HALT
  function automatic void load_stream(input logic [7:0] p);
    logic [7:0] a;
    expq.delete();
    for (int i = 0; i < 300; i++) begin
      a = p + 8'(i);
      expq.push_back('{rom[a], a});
      if (rom[a] == HALT) break;
    end
  endfunction

  // scoreboard monitor
  always @(negedge clk) begin
    if (!reset) begin
      expq.delete();
      running = 0;
      mpc = 8'd0;
    end else begin
      if (instr_valid && ready) begin
        if (expq.size() == 0) chk("unexpected_valid", instr_valid, 0);
        else begin
          me = expq.pop_front();
          chk("instr", instr_out, me.instr);
          chk("instr_pc", instr_pc, me.pc);
        end
      end
      if (redirect_valid) begin
        if (running) load_stream(redirect_pc);
        else mpc = redirect_pc;
      end else if (start && !running) begin
        running = 1;
        load_stream(mpc);
      end
    end
  end

  always @(negedge clk)
    if (!reset) iss2.delete();
    else if (imem_rd_en2) iss2.push_back(imem_addr2);

  function automatic logic [31:0] rword(input int halt_odds);
    logic [31:0] w;
    w = $urandom;
    if (w == HALT) w = 32'h1;
    if (halt_odds != 0 && $urandom_range(halt_odds - 1, 0) == 0) w = HALT;
    return w;
  endfunction

  task automatic fill(input int halt_odds);
    for (int i = 0; i < 256; i++) rom[i] = rword(halt_odds);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    reset = 0; start = 0; start2 = 0; ready = 0; redirect_valid = 0;
    repeat (2) tick;
    reset = 1;
    tick;
  endtask

  task automatic pulse_start;
    start = 1;
    tick;
    start = 0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_rd_en"}, imem_rd_en, 0);
    chk({tag, "_addr"}, imem_addr, 0);
    chk({tag, "_valid"}, instr_valid, 0);
    chk({tag, "_instr"}, instr_out, 0);
    chk({tag, "_pc"}, instr_pc, 0);
    chk({tag, "_halted"}, halted, 0);
  endtask

  task automatic wait_halted;
    int n = 0;
    while (!halted && n < 50) begin tick; n++; end
    chk("halt_reached", halted, 1);
  endtask

  task automatic wait_drained;
    int n = 0;
    while (expq.size() != 0 && n < 50) begin tick; n++; end
    chk("stream_drained", expq.size(), 0);
  endtask

  task automatic wait_valid;
    int n = 0;
    #2;
    while (!instr_valid && n < 20) begin tick; #2; n++; end
    chk("valid_seen", instr_valid, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    for (int i = 0; i < 16; i++) rom2[i] = 32'h5;
    rom2[2] = HALT;
    #2 reset = 0;
    #1 check_reset_outputs("reset");
    repeat (2) tick;
    reset = 1;
    tick;

    // basic run with latency and halt
    fill(0);
    rom[0] = 32'd11; rom[1] = 32'd22; rom[2] = 32'd33; rom[3] = HALT;
    do_reset;
    ready = 1;
    start = 1;
    #2 chk("lat_c0", instr_valid, 0);
    tick; start = 0;
    #2 chk("lat_c1", instr_valid, 0);
    for (int i = 0; i < 4; i++) begin tick; #2 chk("consecutive_valid", instr_valid, 1); end
    wait_halted;
    for (int i = 0; i < 3; i++) begin tick; chk("no_issue_halted", imem_rd_en, 0); end
    wait_drained;

    // backpressure
    do_reset;
    pulse_start;
    repeat (5) begin tick; #2 if (instr_valid) chk("bp_hold_instr", instr_out, 32'd11); end
    chk("bp_valid", instr_valid, 1);
    chk("bp_instr", instr_out, 32'd11);
    chk("bp_pc", instr_pc, 0);
    chk("bp_rd_en_full", imem_rd_en, 0);
    chk("bp_count", dut.u_q.count, 2);
    ready = 1;
    wait_halted;
    wait_drained;

    // redirect while addr 2 is inflight
    fill(0);
    rom[7] = HALT; rom[8'h44] = HALT; rom[5] = 32'h55;
    do_reset;
    ready = 1;
    pulse_start;
    n = 0;
    #2;
    while (!(imem_rd_en && imem_addr == 8'd2) && n < 20) begin tick; #2; n++; end
    chk("addr2_issued", imem_addr, 2);
    tick;
    redirect_valid = 1; redirect_pc = 8'h40;
    tick;
    redirect_valid = 0;
    wait_valid;
    chk("redirect_first_pc", instr_pc, 8'h40);
    wait_halted;
    wait_drained;

    // redirect while halted
    redirect_valid = 1; redirect_pc = 8'd5;
    tick;
    redirect_valid = 0;
    chk("halted_dropped", halted, 0);
    wait_valid;
    chk("resume_pc", instr_pc, 5);
    wait_halted;
    wait_drained;

    // async reset with a full queue
    fill(0);
    do_reset;
    pulse_start;
    repeat (5) tick;
    chk("full_before_reset", dut.u_q.count, 2);
    @(posedge clk);
    #3 reset = 0;
    #1 check_reset_outputs("async");
    tick;
    reset = 1;
    tick;
    ready = 1;
    pulse_start;
    wait_valid;
    chk("restart_pc", instr_pc, 0);
    repeat (20) tick;

    // randomized traffic with redirects and sprinkled HALT words
    for (int r = 0; r < 4; r++) begin
      fill(12);
      do_reset;
      redirect_valid = 1; redirect_pc = 8'($urandom);
      tick;
      redirect_valid = 0;
      pulse_start;
      for (int c = 0; c < 600; c++) begin
        ready = $urandom_range(3, 0) != 0;
        redirect_valid = $urandom_range(19, 0) == 0;
        redirect_pc = 8'($urandom);
        tick;
      end
      redirect_valid = 0;
      ready = 1;
      repeat (4) tick;
    end

    // pc wrap on a 4-bit address space starting at 14
    do_reset;
    start2 = 1;
    tick;
    start2 = 0;
    repeat (10) tick;
    chk("wrap_issue_count", iss2.size(), 5);
    if (iss2.size() >= 4) begin
      chk("wrap_a0", iss2[0], 14);
      chk("wrap_a1", iss2[1], 15);
      chk("wrap_a2", iss2[2], 0);
      chk("wrap_a3", iss2[3], 1);
    end
    chk("wrap_halted", halted2, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
